// File: rtl/imm_pkg.sv
// Shared immediate-format encodings and range helpers for the immediate
// encoder and the sign_extension decoder.
package imm_pkg;

    typedef enum logic [2:0] {
        IMM_I  = 3'b000,
        IMM_S  = 3'b001,
        IMM_SB = 3'b010,
        IMM_U  = 3'b011,
        IMM_UJ = 3'b100
    } imm_type_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // True when v[63:lsb] is a pure sign run, i.e. v survives truncation to lsb+1 bits.
    function automatic logic sign_run(input logic [63:0] v, input int unsigned lsb);
        logic signed [63:0] s;
        s = $signed(v) >>> lsb;
        return (s == 64'sd0) || (s == -64'sd1);
    endfunction

endpackage

// File: rtl/imm_pack.sv
// Combinational merge of an immediate into its instruction bit positions,
// with the per-format range/alignment check.
module imm_pack
    import imm_pkg::*;
(
    input  logic [31:0] base_instr,
    input  logic [2:0]  imm_type,
    input  logic [63:0] imm,
    output logic [31:0] instr,
    output logic        err
);

    always_comb begin
        instr = base_instr;
        err   = 1'b0;
        case (imm_type)
            IMM_I: begin
                instr[31:20] = imm[11:0];
                err          = !sign_run(imm, 11);
            end
            IMM_S: begin
                instr[31:25] = imm[11:5];
                instr[11:7]  = imm[4:0];
                err          = !sign_run(imm, 11);
            end
            IMM_SB: begin
                instr[31]    = imm[12];
                instr[7]     = imm[11];
                instr[30:25] = imm[10:5];
                instr[11:8]  = imm[4:1];
                err          = !sign_run(imm, 12) || imm[0];
            end
            IMM_U: begin
                instr[31:12] = imm[63:44];
                err          = |imm[43:0];
            end
            IMM_UJ: begin
                // The sign bit comes from imm[63], not imm[52], so an out-of-range
                // value still carries its true sign in the encoding.
                instr[31]    = imm[63];
                instr[19:12] = imm[51:44];
                instr[20]    = imm[43];
                instr[30:21] = imm[42:33];
                err          = !sign_run(imm, 52) || (|imm[32:0]);
            end
            default: begin
                instr = NOP_INSTR;
                err   = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_encoder.sv
// Two-stage valid/ready immediate encoder: S1 holds the request fields, S2 holds
// the merged instruction and error flag, plus delivered/error counters.
module imm_encoder
    import imm_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      base_instr,
    input  logic [2:0]       imm_type,
    input  logic [63:0]      imm_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic             imm_err,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    logic        vld_p1;
    logic [31:0] base_p1;
    logic [2:0]  type_p1;
    logic [63:0] imm_p1;

    logic        vld_p2;
    logic [31:0] instr_p2;
    logic        err_p2;

    logic [31:0] merged_instr;
    logic        merged_err;
    logic        s1_adv;
    logic        out_xfer;

    assign s1_adv    = !vld_p2 || out_ready;
    assign in_ready  = !vld_p1 || s1_adv;
    assign out_xfer  = vld_p2 && out_ready;

    assign out_valid = vld_p2;
    assign instr_out = instr_p2;
    assign imm_err   = err_p2;

    // Stage S1: capture request fields on acceptance
    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            base_p1 <= base_instr;
            type_p1 <= imm_type;
            imm_p1  <= imm_in;
        end
    end

    imm_pack u_imm_pack (
        .base_instr (base_p1),
        .imm_type   (type_p1),
        .imm        (imm_p1),
        .instr      (merged_instr),
        .err        (merged_err)
    );

    // Stage S2: register merged result; control, outputs and counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1    <= 1'b0;
            vld_p2    <= 1'b0;
            instr_p2  <= 32'h0;
            err_p2    <= 1'b0;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            if (in_ready) begin
                vld_p1 <= in_valid;
            end
            if (s1_adv) begin
                vld_p2 <= vld_p1;
                if (vld_p1) begin
                    instr_p2 <= merged_instr;
                    err_p2   <= merged_err;
                end
            end
            if (out_xfer) begin
                enc_count <= enc_count + 1'b1;
                if (err_p2) begin
                    err_count <= sat_inc(err_count);
                end
            end
        end
    end

endmodule

// File: tb/tb_imm_encoder.sv
// Bench for imm_encoder: directed format cases, backpressure, reset and
// randomized traffic against a decoder-based reference model.
module tb_imm_encoder;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] base_instr;
    logic [2:0]  imm_type;
    logic [63:0] imm_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic        imm_err;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    imm_encoder #(.CNT_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .base_instr (base_instr),
        .imm_type   (imm_type),
        .imm_in     (imm_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .instr_out  (instr_out),
        .imm_err    (imm_err),
        .enc_count  (enc_count),
        .err_count  (err_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] instr;
        logic        err;
        logic [2:0]  t;
        logic [63:0] imm;
    } exp_t;

    exp_t        q[$];
    int          total = 0;
    int          bad = 0;
    logic [15:0] exp_enc = 16'd0;
    logic [15:0] exp_err = 16'd0;
    logic        stall_seen = 1'b0;
    logic [31:0] held_instr;
    logic        held_err;

    // Reference decoder (sign_extension behaviour): instruction fields -> 64-bit immediate.
    function automatic longint dec(input logic [2:0] t, input logic [31:0] x);
        logic signed [11:0] fi;
        logic signed [12:0] fb;
        logic signed [19:0] fj;
        case (t)
            3'd0: begin fi = x[31:20]; return longint'(fi); end
            3'd1: begin fi = {x[31:25], x[11:7]}; return longint'(fi); end
            3'd2: begin fb = {x[31], x[7], x[30:25], x[11:8], 1'b0}; return longint'(fb); end
            3'd3: return longint'({x[31:12], 44'd0});
            3'd4: begin fj = {x[31], x[19:12], x[20], x[30:21]}; return longint'(fj) <<< 33; end
            default: return 64'd0;
        endcase
    endfunction

    // Each immediate-carrying instruction bit is found by probing the decoder with
    // that bit alone; it takes the immediate bit at the lowest set bit of the result.
    function automatic logic [31:0] enc_model(input logic [31:0] base, input logic [2:0] t,
                                              input logic [63:0] imm);
        logic [31:0] r;
        logic [31:0] probe;
        logic [63:0] d;
        int          pos;
        if (t > 3'd4) return 32'h0000_0013;
        r = base;
        for (int k = 0; k < 32; k++) begin
            probe = 32'd1 << k;
            d = dec(t, probe);
            if (d != 64'd0) begin
                pos = 0;
                while (d[pos] == 1'b0) pos++;
                if (t == 3'd4 && k == 31) pos = 63;
                r[k] = imm[pos];
            end
        end
        return r;
    endfunction

    function automatic logic err_model(input logic [2:0] t, input logic [63:0] imm);
        longint s;
        s = imm;
        case (t)
            3'd0, 3'd1: return !(s >= -2048 && s <= 2047);
            3'd2:       return !(s >= -4096 && s <= 4095 && imm[0] == 1'b0);
            3'd3:       return (s & ((64'sd1 <<< 44) - 1)) != 0;
            3'd4:       return !((s & ((64'sd1 <<< 33) - 1)) == 0 && ((s >>> 52) == 0 || (s >>> 52) == -1));
            default:    return 1'b1;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        assert (obs === expv) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // One clock: settle inputs, account for transfers that the next edge performs, then advance.
    task automatic cycle();
        exp_t e;
        #1;
        if (stall_seen) begin
            chk("hold_vld", out_valid, 1);
            chk("hold_instr", instr_out, held_instr);
            chk("hold_err", imm_err, held_err);
        end
        stall_seen = out_valid && !out_ready;
        held_instr = instr_out;
        held_err   = imm_err;
        if (in_valid && in_ready) begin
            e.instr = enc_model(base_instr, imm_type, imm_in);
            e.err   = err_model(imm_type, imm_in);
            e.t     = imm_type;
            e.imm   = imm_in;
            q.push_back(e);
        end
        if (out_valid && out_ready) begin
            if (q.size() == 0) begin
                chk("spurious_out", 1, 0);
            end else begin
                e = q.pop_front();
                chk("instr_out", instr_out, e.instr);
                chk("imm_err", imm_err, e.err);
                if (e.t <= 3'd4 && !e.err) chk("roundtrip", dec(e.t, instr_out), e.imm);
                exp_enc = exp_enc + 16'd1;
                if (e.err && exp_err != 16'hFFFF) exp_err = exp_err + 16'd1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n = 0;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        while (q.size() != 0 && n < 50) begin
            cycle();
            n++;
        end
        chk("drain_timeout", q.size(), 0);
        cycle();
        chk("enc_count", enc_count, exp_enc);
        chk("err_count", err_count, exp_err);
    endtask

    task automatic directed(input string tag, input logic [31:0] base, input logic [2:0] t,
                            input logic [63:0] imm, input logic [31:0] want, input logic want_err);
        base_instr = base;
        imm_type   = t;
        imm_in     = imm;
        in_valid   = 1'b1;
        out_ready  = 1'b1;
        cycle();
        in_valid = 1'b0;
        chk({tag, "_lat1"}, out_valid, 0);
        cycle();
        chk({tag, "_lat2"}, out_valid, 1);
        chk({tag, "_instr"}, instr_out, want);
        chk({tag, "_err"}, imm_err, want_err);
        drain();
    endtask

    task automatic rand_req();
        int r;
        r = $urandom_range(0, 9);
        imm_type   = (r < 8) ? 3'(r % 5) : 3'($urandom_range(5, 7));
        base_instr = $urandom;
        if ($urandom_range(0, 2) != 0) imm_in = dec(imm_type, $urandom);
        else imm_in = {$urandom, $urandom} >> $urandom_range(0, 63);
    endtask

    initial begin
        logic        saw_block;
        logic [15:0] bp_start;
        int          sent;
        int          cyc;

        rst_n      = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b0;
        base_instr = 32'h0;
        imm_type   = 3'd0;
        imm_in     = 64'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_instr", instr_out, 0);
        chk("rst_err", imm_err, 0);
        chk("rst_enc", enc_count, 0);
        chk("rst_errcnt", err_count, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        directed("i_ones",   32'h0000_0093, 3'd0, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFFF0_0093, 1'b0);
        directed("sb_8",     32'h0000_0063, 3'd2, 64'd8,                    32'h0000_0463, 1'b0);
        directed("sb_3",     32'h0000_0063, 3'd2, 64'd3,                    32'h0000_0163, 1'b1);
        directed("u_ok",     32'h0000_0037, 3'd3, 64'h1234_5000_0000_0000,  32'h1234_5037, 1'b0);
        directed("u_bad",    32'h0000_0037, 3'd3, 64'h1234_5000_0000_0001,  32'h1234_5037, 1'b1);
        directed("illegal",  32'hFFFF_FFFF, 3'd5, 64'h0,                    32'h0000_0013, 1'b1);
        directed("i_2048",   32'h0000_0013, 3'd0, 64'd2048,                 32'h8000_0013, 1'b1);
        directed("uj_2p33",  32'h0000_006F, 3'd4, 64'd1 << 33,              32'h0020_006F, 1'b0);
        directed("s_neg1",   32'h0000_0023, 3'd1, 64'hFFFF_FFFF_FFFF_FFFF, 32'hFE00_0FA3, 1'b0);

        // Backpressure: four requests while the consumer stalls for three cycles
        bp_start  = exp_enc;
        saw_block = 1'b0;
        sent      = 0;
        cyc       = 0;
        while (sent < 4 && cyc < 20) begin
            rand_req();
            imm_type  = 3'd0;
            imm_in    = dec(3'd0, $urandom);
            in_valid  = 1'b1;
            out_ready = (cyc >= 3);
            #1;
            if (!in_ready) saw_block = 1'b1;
            if (in_ready) sent++;
            cycle();
            cyc++;
        end
        chk("bp_sent", sent, 4);
        chk("bp_in_ready_low", saw_block, 1);
        drain();
        chk("bp_count", enc_count, bp_start + 16'd4);

        // Reset with both stages full
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_req();
        cycle();
        rand_req();
        cycle();
        in_valid = 1'b0;
        cycle();
        chk("pre_rst_out_valid", out_valid, 1);
        chk("pre_rst_in_ready", in_ready, 0);
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_enc", enc_count, 0);
        chk("arst_errcnt", err_count, 0);
        chk("arst_instr", instr_out, 0);
        q.delete();
        exp_enc    = 16'd0;
        exp_err    = 16'd0;
        stall_seen = 1'b0;
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("post_rst_in_ready", in_ready, 1);
            chk("post_rst_no_stale", out_valid, 0);
        end

        // Randomized traffic with random stalls on both sides
        for (int i = 0; i < 300; i++) begin
            rand_req();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            cycle();
        end
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_encoder.md
IMM_ENCODER -- requirements
Module: imm_encoder

Interface
REQ-001 SHALL have parameter CNT_W, default 16, width of the encoded-instruction and error counters.
REQ-002 SHALL have port clk  input  1  the single rising-edge clock.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert and active-low.
REQ-004 SHALL have port in_valid  input  1  the request is valid.
REQ-005 SHALL have port in_ready  output  1  the encoder accepts the request this cycle.
REQ-006 SHALL have port base_instr  input  32  the instruction whose immediate bit positions are overwritten.
REQ-007 SHALL have port imm_type  input  3  the format: 000 I, 001 S, 010 SB, 011 U, 100 UJ, 101-111 illegal.
REQ-008 SHALL have port imm_in  input  64  the signed 64-bit immediate, in the codebase immediate-decode convention.
REQ-009 SHALL have port out_valid  output  1  the encoded result is valid.
REQ-010 SHALL have port out_ready  input  1  the consumer accepts the result.
REQ-011 SHALL have port instr_out  output  32  the encoded instruction.
REQ-012 SHALL have port imm_err  output  1  the result is out of range, misaligned or an illegal type; qualified by out_valid.
REQ-013 SHALL have port enc_count  output  CNT_W  results delivered, wrapping.
REQ-014 SHALL have port err_count  output  CNT_W  delivered results with imm_err=1, saturating at all-ones.

Function
REQ-015 SHALL transfer a request on in_valid&&in_ready and a result on out_valid&&out_ready.
REQ-016 SHALL be a 2-stage pipeline: S1 registers the fields and computes the error, S2 registers the merged instruction; latency 2 cycles, throughput 1 per cycle.
REQ-017 SHALL advance each stage when that stage is empty or the stage downstream advances: in_ready = !s1_valid || s1_adv, and s1_adv = !s2_valid || out_ready.
REQ-018 SHALL hold instr_out, imm_err and out_valid stable while out_valid&&!out_ready.
REQ-019 SHALL encode I-type as instr[31:20]=imm[11:0]; error unless imm[63:11] are all equal.
REQ-020 SHALL encode S-type as instr[31:25]=imm[11:5] and instr[11:7]=imm[4:0]; same range rule as I-type.
REQ-021 SHALL encode SB-type as instr[31]=imm[12], instr[7]=imm[11], instr[30:25]=imm[10:5], instr[11:8]=imm[4:1]; error unless imm[63:12] are all equal and imm[0]=0.
REQ-022 SHALL encode U-type as instr[31:12]=imm[63:44]; error unless imm[43:0]=0.
REQ-023 SHALL encode UJ-type as instr[31]=imm[63], instr[19:12]=imm[51:44], instr[20]=imm[43], instr[30:21]=imm[42:33]; error unless imm[63:52] are all equal and imm[32:0]=0.
REQ-024 SHALL pass every base_instr bit not named for the selected type through unchanged.
REQ-025 SHALL, on an illegal imm_type, output instr_out=32'h00000013 (NOP) with imm_err=1.
REQ-026 SHALL, on an error, still output the truncated field bits, except for illegal types.
REQ-027 SHALL increment enc_count on each output transfer, wrapping from all-ones to 0.
REQ-028 SHALL increment err_count on each output transfer with imm_err=1, holding at all-ones.
REQ-029 SHALL, when S2 drains and S1 refills in the same cycle, lose and duplicate no entry.

Reset
REQ-030 SHALL, on rst_n low, asynchronously clear s1_valid, s2_valid, out_valid, enc_count and err_count, and drive instr_out=0 and imm_err=0.
REQ-031 SHALL, on reset mid-operation, discard in-flight entries and hold in_ready=1 from the first clock after release.

Structure
REQ-032 SHALL take the imm_type encodings (IMM_I, IMM_S, IMM_SB, IMM_U, IMM_UJ) and the NOP constant from a shared package, imm_pkg, also used by sign_extension.
REQ-033 SHALL place the combinational field-merge and range check in one sub-module, imm_pack, instanced in S1/S2; the pipeline and counters SHALL stay in imm_encoder.

Verification
REQ-034 SHALL check I-type: base 0x00000093, imm all-ones -> instr_out 0xFFF00093, imm_err 0, 2 cycles after acceptance.
REQ-035 SHALL check SB-type: base 0x00000063, imm 8 -> 0x00000463, imm_err 0; imm 3 -> imm_err 1, err_count +1.
REQ-036 SHALL check U-type: base 0x00000037, imm 0x1234_5000_0000_0000 -> 0x12345037; imm 0x1234_5000_0000_0001 -> imm_err 1.
REQ-037 SHALL check backpressure: 4 back-to-back requests, out_ready low 3 cycles -> in_ready low once both stages are full, outputs in order, none lost, enc_count=4.
REQ-038 SHALL check round trip: random legal requests fed to sign_extension with the same type -> regenerated imm equals imm_in.
REQ-039 SHALL check reset: rst_n low with both stages full -> out_valid 0 immediately, counters 0, no stale output after release.
